// File: rtl/biset_pkg.sv
// BiSet settings-bus types, accessors and the stream-master command/status codes.
package biset_pkg;

  typedef logic [8:0]  biSetCtrl;   // {writeEnable, addr}; all-zero = idle
  typedef logic [31:0] biSetData;
  typedef logic [32:0] biSetReply;  // {valid, data}

  localparam logic [7:0] BISET_CMD_READ      = 8'h01;
  localparam logic [7:0] BISET_CMD_WRITE     = 8'h02;
  localparam logic [7:0] BISET_STAT_OK       = 8'h00;
  localparam logic [7:0] BISET_STAT_TIMEOUT  = 8'h01;
  localparam logic [7:0] BISET_STAT_BADCMD   = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WAIT,
    S_RESP,
    S_RDATA
  } master_state_e;

  function automatic logic BiSetReplyValid(input biSetReply r);
    return r[32];
  endfunction

  function automatic biSetData BiSetReplyData(input biSetReply r);
    return r[31:0];
  endfunction

  function automatic biSetCtrl BiSetMakeCtrl(input logic we, input logic [7:0] addr);
    return {we, addr};
  endfunction

endpackage

// File: rtl/biset_stream_master.sv
// Byte-stream to BiSet bridge: decodes read/write commands, runs one bus
// transaction with a reply timeout, and streams back status plus read data.
module biset_stream_master
  import biset_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output biSetCtrl      biset_ctrl,
  output biSetData      biset_data,
  input  biSetReply     biset_reply,
  output logic          busy,
  output master_state_e dbg_state
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  // Both streams transfer a byte on a rising edge where valid & ready are high;
  // a presented byte and its valid stay unchanged until that transfer.
  logic in_hs;
  logic out_hs;
  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  master_state_e state;
  logic [15:0]   cnt;
  logic [1:0]    bcnt;
  logic          we;
  logic [7:0]    addr;
  logic [31:0]   shreg;  // write-data assembly, then read-data serialisation

  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      biset_ctrl <= '0;
      biset_data <= '0;
      busy       <= 1'b0;
      cnt        <= '0;
      bcnt       <= '0;
      we         <= 1'b0;
      addr       <= '0;
      shreg      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_hs) begin
            busy <= 1'b1;
            if (in_data == BISET_CMD_READ || in_data == BISET_CMD_WRITE) begin
              we    <= (in_data == BISET_CMD_WRITE);
              state <= S_ADDR;
            end else begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= BISET_STAT_BADCMD;
              state     <= S_RESP;
            end
          end
        end
        S_ADDR: begin
          if (in_hs) begin
            addr <= in_data;
            bcnt <= '0;
            if (we) begin
              state <= S_WDATA;
            end else if (in_data == 8'h00) begin
              // A read of address 0 would look like an idle bus.
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= BISET_STAT_BADCMD;
              state     <= S_RESP;
            end else begin
              in_ready   <= 1'b0;
              biset_ctrl <= BiSetMakeCtrl(1'b0, in_data);
              biset_data <= '0;
              cnt        <= '0;
              state      <= S_WAIT;
            end
          end
        end
        S_WDATA: begin
          if (in_hs) begin
            shreg <= {shreg[23:0], in_data};
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              in_ready   <= 1'b0;
              biset_ctrl <= BiSetMakeCtrl(1'b1, addr);
              biset_data <= {shreg[23:0], in_data};
              cnt        <= '0;
              state      <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A reply on the timeout cycle still counts as success.
          if (BiSetReplyValid(biset_reply)) begin
            if (!we) shreg <= BiSetReplyData(biset_reply);
            biset_ctrl <= '0;
            biset_data <= '0;
            out_valid  <= 1'b1;
            out_data   <= BISET_STAT_OK;
            state      <= S_RESP;
          end else if (cnt == TMO_LAST) begin
            biset_ctrl <= '0;
            biset_data <= '0;
            out_valid  <= 1'b1;
            out_data   <= BISET_STAT_TIMEOUT;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_RESP: begin
          if (out_hs) begin
            if (!we && out_data == BISET_STAT_OK) begin
              out_data <= shreg[31:24];
              shreg    <= {shreg[23:0], 8'h00};
              bcnt     <= '0;
              state    <= S_RDATA;
            end else begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        S_RDATA: begin
          if (out_hs) begin
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state     <= S_IDLE;
            end else begin
              out_data <= shreg[31:24];
              shreg    <= {shreg[23:0], 8'h00};
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biset_stream_master.sv
// Bench for biset_stream_master: directed scenarios plus random commands against
// a transaction-level model of bus activity and response bytes.
module tb_biset_stream_master;
  import biset_pkg::*;

  localparam int TMO = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  biSetCtrl      biset_ctrl;
  biSetData      biset_data;
  biSetReply     biset_reply = '0;
  logic          busy;
  master_state_e dbg_state;

  biset_stream_master #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .biset_ctrl(biset_ctrl), .biset_data(biset_data), .biset_reply(biset_reply),
    .busy(busy), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // model state for the current command
  logic [7:0]  exp_q[$];
  logic [8:0]  exp_ctrl = '0;
  logic [31:0] exp_wdata = '0;
  logic [31:0] reply_word = '0;
  int          exp_cycles = 0;
  int          reply_delay = -1;
  int          en_cnt = 0;
  bit          spurious = 1'b0;
  bit          rdy_random = 1'b0;
  logic [7:0]  prev_out = '0;
  bit          prev_stall = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the bus and the response stream must show for one command.
  // delay = enabled cycle in which the slave replies (1 = same cycle), -1 = never.
  task automatic expect_cmd(input logic [7:0] op, input logic [7:0] addr,
                            input logic [31:0] wdata, input int delay, input logic [31:0] word);
    bit is_wr;
    bit replied;
    reply_delay = delay;
    reply_word  = word;
    en_cnt      = 0;
    is_wr       = (op == 8'h02);
    if ((op != 8'h01 && op != 8'h02) || (op == 8'h01 && addr == 8'h00)) begin
      exp_ctrl   = '0;
      exp_wdata  = '0;
      exp_cycles = 0;
      exp_q.push_back(8'h02);
    end else begin
      replied    = (delay >= 1 && delay <= TMO);
      exp_ctrl   = {is_wr, addr};
      exp_wdata  = is_wr ? wdata : 32'h0;
      exp_cycles = replied ? delay : TMO;
      exp_q.push_back(replied ? 8'h00 : 8'h01);
      if (replied && !is_wr)
        for (int i = 3; i >= 0; i--) exp_q.push_back(word[i*8 +: 8]);
    end
  endtask

  // driver tasks: entered and left at posedge + 1
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_handshake", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [7:0] addr, input logic [31:0] wdata);
    send_byte(op);
    if (op == 8'h01 || op == 8'h02) send_byte(addr);
    if (op == 8'h02)
      for (int i = 3; i >= 0; i--) send_byte(wdata[i*8 +: 8]);
  endtask

  task automatic finish_cmd(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_complete"}, (n < 400), 1'b1);
    check({name, "_ctrl_cycles"}, en_cnt, exp_cycles);
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [7:0] addr, input logic [31:0] wdata,
                         input int delay, input logic [31:0] word, input string name);
    expect_cmd(op, addr, wdata, delay, word);
    send_cmd(op, addr, wdata);
    finish_cmd(name);
    @(posedge clk);
    #1;
  endtask

  // response sink
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // compare process plus slave: runs on every falling edge
  always @(negedge clk) begin
    if (reset_n) begin
      if (biset_ctrl != '0) begin
        en_cnt++;
        check("ctrl", biset_ctrl, exp_ctrl);
        check("wdata", biset_data, exp_wdata);
        check("in_ready_in_wait", in_ready, 1'b0);
        check("busy_in_wait", busy, 1'b1);
        biset_reply = (en_cnt == reply_delay) ? {1'b1, reply_word} : '0;
      end else begin
        biset_reply = (spurious && $urandom_range(0, 1) == 1) ? {1'b1, 32'($urandom)} : '0;
      end
      if (out_valid) begin
        check("busy_in_resp", busy, 1'b1);
        check("in_ready_in_resp", in_ready, 1'b0);
        if (prev_stall) check("out_stable", out_data, prev_out);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_extra: got 0x%0h expected no byte at %0t", out_data, $time);
          end else begin
            check("resp_byte", out_data, exp_q.pop_front());
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  op;
    logic [7:0]  addr;
    int          delay;
    int          r;

    // reset values
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_ctrl", biset_ctrl, 9'h000);
    check("rst_data", biset_data, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, S_IDLE);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // write, slave replies in the third enabled cycle
    expect_cmd(8'h02, 8'h10, 32'hDEADBEEF, 3, 32'h0);
    send_cmd(8'h02, 8'h10, 32'hDEADBEEF);
    @(negedge clk);
    check("wr_ctrl_lit", biset_ctrl, 9'h110);
    check("wr_data_lit", biset_data, 32'hDEADBEEF);
    finish_cmd("write");
    check("wr_cycles_lit", en_cnt, 3);
    @(posedge clk);
    #1;

    // read, same-cycle reply: ctrl in cycle 2, status in cycle 3
    expect_cmd(8'h01, 8'h25, 32'h0, 1, 32'h12345678);
    send_byte(8'h01);
    send_byte(8'h25);
    @(negedge clk);
    check("rd_ctrl_lit", biset_ctrl, 9'h025);
    @(negedge clk);
    check("rd_status_valid_lit", out_valid, 1'b1);
    check("rd_status_lit", out_data, 8'h00);
    check("rd_ctrl_idle_lit", biset_ctrl, 9'h000);
    finish_cmd("read");
    check("rd_cycles_lit", en_cnt, 1);
    @(posedge clk);
    #1;

    // timeout
    run_cmd(8'h01, 8'h33, 32'h0, -1, 32'h0, "timeout");
    check("to_cycles_lit", en_cnt, TMO);
    check("ready_after_timeout", in_ready, 1'b1);

    // reply in the very last cycle before timeout wins
    run_cmd(8'h01, 8'h34, 32'h0, TMO, 32'hCAFE0001, "late_reply");

    // bad commands then a good read
    run_cmd(8'h7F, 8'h00, 32'h0, 1, 32'h0, "bad_opcode");
    run_cmd(8'h01, 8'h00, 32'h0, 1, 32'h0, "read_addr0");
    run_cmd(8'h01, 8'h44, 32'h0, 2, 32'h0BADF00D, "read_after_bad");

    // stalled output with spurious replies outside WAIT
    rdy_random = 1'b1;
    spurious   = 1'b1;
    run_cmd(8'h01, 8'h5A, 32'h0, 4, 32'hA5C30F96, "stall_read");

    // reset in the middle of WAIT
    rdy_random = 1'b0;
    spurious   = 1'b0;
    expect_cmd(8'h02, 8'h55, 32'h01020304, -1, 32'h0);
    send_cmd(8'h02, 8'h55, 32'h01020304);
    repeat (3) @(negedge clk);
    check("pre_reset_ctrl", biset_ctrl, 9'h155);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_ctrl", biset_ctrl, 9'h000);
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_midreset", in_ready, 1'b1);
    @(posedge clk);
    #1;
    run_cmd(8'h02, 8'h66, 32'hCAFEF00D, 2, 32'h0, "write_after_reset");

    // random commands
    rdy_random = 1'b1;
    spurious   = 1'b1;
    for (int t = 0; t < 60; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      r = $urandom_range(0, 9);
      if (r < 4)      op = 8'h01;
      else if (r < 8) op = 8'h02;
      else            op = 8'($urandom);
      addr  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      delay = $urandom_range(0, 11);
      if (delay == 0) delay = -1;
      run_cmd(op, addr, $urandom, delay, $urandom, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
